// File: rtl/ailn_output_packer.sv
// Packs serial signed result bytes from AILayerNorm into DATA_WIDTH-bit words.
// Ports: i_clk, i_rstn (sync, low), i_clear, i_valid/i_data in, i_ready,
//        o_valid/o_data out, o_cnt fill count, o_busy, o_overflow (sticky).
module ailn_output_packer #(
  parameter int DATA_WIDTH = 192
) (
  input  logic                  i_clk,
  input  logic                  i_rstn,
  input  logic                  i_clear,
  input  logic                  i_valid,
  input  logic [7:0]            i_data,
  input  logic                  i_ready,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic [$clog2(DATA_WIDTH/8):0] o_cnt,
  output logic                  o_busy,
  output logic                  o_overflow
);

  localparam int COUNT     = DATA_WIDTH / 8;
  localparam int CNT_WIDTH = $clog2(COUNT);
  localparam logic [CNT_WIDTH:0] LAST =
    (CNT_WIDTH + 1)'(COUNT - 1);
  localparam logic [DATA_WIDTH-1:0] TOP_MASK =
    {8'hFF, {(DATA_WIDTH - 8){1'b0}}};

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    FILLING = 2'd1,
    FULL    = 2'd2
  } bank_st_e;

  bank_st_e              st_q   [2];
  bank_st_e              st_d   [2];
  logic [DATA_WIDTH-1:0] bank_q [2];
  logic [DATA_WIDTH-1:0] bank_d [2];
  logic                  wr_sel_q, wr_sel_d;
  logic                  rd_sel_q, rd_sel_d;
  logic [CNT_WIDTH:0]    cnt_q, cnt_d;
  logic                  ovf_q, ovf_d;
  logic                  vld_q, vld_d;
  logic [DATA_WIDTH-1:0] dat_q, dat_d;

  logic                  hs;
  logic                  wr_full;
  logic                  accept;
  logic                  drop;
  logic [CNT_WIDTH+3:0]  sh;

  assign hs      = vld_q & i_ready;
  assign wr_full = (st_q[wr_sel_q] == FULL);
  assign accept  = i_valid & ~wr_full;
  assign drop    = i_valid & wr_full;
  // byte k sits k bytes below the top of the word
  assign sh      = {cnt_q, 3'b000};

  always_comb begin
    st_d[0]   = st_q[0];
    st_d[1]   = st_q[1];
    bank_d[0] = bank_q[0];
    bank_d[1] = bank_q[1];
    wr_sel_d  = wr_sel_q;
    rd_sel_d  = rd_sel_q;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    vld_d     = 1'b0;
    dat_d     = '0;

    if (hs) begin
      st_d[rd_sel_q] = EMPTY;
      rd_sel_d       = ~rd_sel_q;
    end

    if (accept) begin
      bank_d[wr_sel_q] =
        (bank_q[wr_sel_q] & ~(TOP_MASK >> sh)) |
        ({i_data, {(DATA_WIDTH - 8){1'b0}}} >> sh);
      if (cnt_q == LAST) begin
        st_d[wr_sel_q] = FULL;
        cnt_d          = '0;
        wr_sel_d       = ~wr_sel_q;
      end else begin
        st_d[wr_sel_q] = FILLING;
        cnt_d          = cnt_q + 1'b1;
      end
    end

    if (drop) ovf_d = 1'b1;

    vld_d = (st_d[rd_sel_d] == FULL);
    dat_d = bank_d[rd_sel_d];

    if (i_clear) begin
      st_d[0]   = EMPTY;
      st_d[1]   = EMPTY;
      bank_d[0] = '0;
      bank_d[1] = '0;
      wr_sel_d  = 1'b0;
      rd_sel_d  = 1'b0;
      cnt_d     = '0;
      ovf_d     = 1'b0;
      vld_d     = 1'b0;
      dat_d     = '0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      st_q[0]   <= EMPTY;
      st_q[1]   <= EMPTY;
      bank_q[0] <= '0;
      bank_q[1] <= '0;
      wr_sel_q  <= 1'b0;
      rd_sel_q  <= 1'b0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      vld_q     <= 1'b0;
      dat_q     <= '0;
    end else begin
      st_q[0]   <= st_d[0];
      st_q[1]   <= st_d[1];
      bank_q[0] <= bank_d[0];
      bank_q[1] <= bank_d[1];
      wr_sel_q  <= wr_sel_d;
      rd_sel_q  <= rd_sel_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      vld_q     <= vld_d;
      dat_q     <= dat_d;
    end
  end

  assign o_valid    = vld_q;
  assign o_data     = dat_q;
  assign o_cnt      = cnt_q;
  assign o_busy     = (st_q[0] != EMPTY) | (st_q[1] != EMPTY);
  assign o_overflow = ovf_q;

endmodule

// File: tb/tb_ailn_output_packer.sv
// Scoreboard bench for ailn_output_packer: directed vectors, queued
// expected words, negedge monitor comparing every output handshake.
module tb_ailn_output_packer;

  logic         clk;
  logic         i_rstn;
  logic         i_clear;
  logic         i_valid;
  logic [7:0]   i_data;
  logic         i_ready;
  logic         o_valid;
  logic [191:0] o_data;
  logic [5:0]   o_cnt;
  logic         o_busy;
  logic         o_overflow;

  int tests = 0;
  int fails = 0;

  logic [191:0] sb[$];
  logic         hold_chk = 1'b0;
  logic [191:0] held;

  logic [191:0] w_a, w_b, w_c, w_s, w_d;

  ailn_output_packer #(.DATA_WIDTH(192)) dut (
    .i_clk      (clk),
    .i_rstn     (i_rstn),
    .i_clear    (i_clear),
    .i_valid    (i_valid),
    .i_data     (i_data),
    .i_ready    (i_ready),
    .o_valid    (o_valid),
    .o_data     (o_data),
    .o_cnt      (o_cnt),
    .o_busy     (o_busy),
    .o_overflow (o_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [191:0] act,
                     input logic [191:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: pops expected words on handshakes, checks hold stability.
  always @(negedge clk) begin
    if (i_rstn && !i_clear && o_valid) begin
      if (hold_chk) chk("hold_stable", o_data, held);
      if (i_ready) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_word: got %h expected none", o_data);
        end else begin
          chk("word", o_data, sb.pop_front());
        end
        hold_chk = 1'b0;
      end else begin
        hold_chk = 1'b1;
        held     = o_data;
      end
    end else begin
      hold_chk = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [191:0] w);
    for (int k = 0; k < 24; k++) begin
      i_valid = 1'b1;
      i_data  = w[191 - 8*k -: 8];
      tick();
    end
    i_valid = 1'b0;
    i_data  = 8'h00;
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && sb.size() != 0; i++) tick();
    chk("drain_empty", 192'(sb.size()), 192'd0);
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_valid"}, 192'(o_valid), 192'd0);
    chk({nm, "_data"},  o_data, 192'd0);
    chk({nm, "_cnt"},   192'(o_cnt), 192'd0);
    chk({nm, "_busy"},  192'(o_busy), 192'd0);
    chk({nm, "_ovf"},   192'(o_overflow), 192'd0);
  endtask

  task automatic basic_fill(input string nm);
    i_ready = 1'b1;
    sb.push_back(w_a);
    send_word(w_a);
    chk({nm, "_valid_rise"}, 192'(o_valid), 192'd1);
    chk({nm, "_top_byte"}, 192'(o_data[191:184]), 192'h01);
    chk({nm, "_low_byte"}, 192'(o_data[7:0]), 192'h18);
    tick();
    chk({nm, "_valid_drop"}, 192'(o_valid), 192'd0);
    drain();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    for (int k = 0; k < 24; k++) begin
      w_a[191 - 8*k -: 8] = 8'(8'h01 + k);
      w_b[191 - 8*k -: 8] = 8'(8'h21 + k);
      w_c[191 - 8*k -: 8] = 8'(8'hA0 + k);
      w_d[191 - 8*k -: 8] = 8'(8'h41 + k);
      case (k % 4)
        0:       w_s[191 - 8*k -: 8] = 8'h80;
        1:       w_s[191 - 8*k -: 8] = 8'h7F;
        2:       w_s[191 - 8*k -: 8] = 8'hFF;
        default: w_s[191 - 8*k -: 8] = 8'h00;
      endcase
    end

    i_rstn  = 1'b0;
    i_clear = 1'b0;
    i_valid = 1'b0;
    i_data  = 8'h00;
    i_ready = 1'b0;
    tick();
    tick();
    chk_zero("reset");
    i_rstn = 1'b1;
    tick();

    // basic fill
    basic_fill("basic");

    // backpressure / ping-pong
    i_ready = 1'b0;
    sb.push_back(w_a);
    send_word(w_a);
    sb.push_back(w_b);
    send_word(w_b);
    tick();
    tick();
    chk("pp_held_a", o_data, w_a);
    chk("pp_busy", 192'(o_busy), 192'd1);

    // overflow: both banks full
    i_valid = 1'b1;
    i_data  = 8'h55;
    tick();
    i_valid = 1'b0;
    chk("ovf_set", 192'(o_overflow), 192'd1);
    chk("ovf_cnt", 192'(o_cnt), 192'd0);
    i_ready = 1'b1;
    tick();
    i_ready = 1'b0;
    sb.push_back(w_c);
    send_word(w_c);
    chk("ovf_sticky", 192'(o_overflow), 192'd1);
    i_ready = 1'b1;
    drain();

    // signed bytes round-trip
    sb.push_back(w_s);
    send_word(w_s);
    drain();

    // clear mid-fill, with a byte on the same cycle
    for (int k = 0; k < 10; k++) begin
      i_valid = 1'b1;
      i_data  = 8'hEE;
      tick();
    end
    chk("pre_clear_cnt", 192'(o_cnt), 192'd10);
    i_clear = 1'b1;
    i_data  = 8'hEE;
    tick();
    i_clear = 1'b0;
    i_valid = 1'b0;
    chk("clear_cnt", 192'(o_cnt), 192'd0);
    chk("clear_busy", 192'(o_busy), 192'd0);
    chk("clear_ovf", 192'(o_overflow), 192'd0);
    sb.push_back(w_d);
    send_word(w_d);
    drain();

    // reset mid-handshake
    i_ready = 1'b0;
    send_word(w_b);
    tick();
    chk("prerst_valid", 192'(o_valid), 192'd1);
    i_rstn = 1'b0;
    tick();
    i_rstn = 1'b1;
    chk_zero("midrst");
    basic_fill("post_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
